// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: measures an asynchronous clock (mon_clk_i) in clk_i cycles.
// Reports the period averaged over 2**AVG_LOG2 periods, and flags periods that are
// too short, too long, or a clock that has stopped. mon_clk_i is sampled as data only.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | monitor disabled; counter, accumulator and sample count cleared
//  ARM   | waiting for the first edge; the partial period before it is dropped
//  MEAS  | counting clk_i cycles between edges and accumulating periods
module clk_freq_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int AVG_LOG2    = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             mon_clk_i,
    input  logic [CNT_W-1:0] min_period_i,
    input  logic [CNT_W-1:0] max_period_i,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o,
    output logic             too_fast_o,
    output logic             too_slow_o,
    output logic             stopped_o
);

    localparam int               ACC_W      = CNT_W + AVG_LOG2;
    localparam int               NS_W       = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [NS_W-1:0]  NSAMP_FULL = NS_W'(1 << AVG_LOG2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ACC_W-1:0]       acc_q;
    logic [NS_W-1:0]        nsamp_q;

    logic [ACC_W-1:0]       acc_next;
    logic [NS_W-1:0]        nsamp_next;
    logic                   fast_hit;
    logic                   slow_hit;

    // Synchronize mon_clk_i and register a one-cycle pulse on each rising edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    // On a rise cnt_q holds the finished period; bounds are compared live every cycle.
    always_comb begin
        acc_next   = acc_q + ACC_W'(cnt_q);
        nsamp_next = nsamp_q + NS_W'(1);
        fast_hit   = (min_period_i != '0) && (cnt_q < min_period_i);
        slow_hit   = (max_period_i != '0) && (cnt_q == max_period_i);
    end

    // Measurement FSM; clr is applied first so a coincident set condition wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            acc_q          <= '0;
            nsamp_q        <= '0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
            too_fast_o     <= 1'b0;
            too_slow_o     <= 1'b0;
            stopped_o      <= 1'b0;
        end else begin
            period_valid_o <= 1'b0;
            if (clr_i) begin
                too_fast_o <= 1'b0;
                too_slow_o <= 1'b0;
            end
            if (!en_i) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                acc_q     <= '0;
                nsamp_q   <= '0;
                stopped_o <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q   <= ARM;
                        cnt_q     <= '0;
                        acc_q     <= '0;
                        nsamp_q   <= '0;
                        stopped_o <= 1'b0;
                    end
                    ARM: begin
                        if (rise_q) begin
                            state_q <= MEAS;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    MEAS: begin
                        if (rise_q) begin
                            cnt_q     <= CNT_W'(1);
                            stopped_o <= 1'b0;
                            if (fast_hit) begin
                                too_fast_o <= 1'b1;
                            end
                            if (nsamp_next == NSAMP_FULL) begin
                                period_o       <= acc_next[ACC_W-1:AVG_LOG2];
                                period_valid_o <= 1'b1;
                                acc_q          <= '0;
                                nsamp_q        <= '0;
                            end else begin
                                acc_q   <= acc_next;
                                nsamp_q <= nsamp_next;
                            end
                        end else begin
                            if (cnt_q != CNT_MAX) begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                            if (slow_hit) begin
                                too_slow_o <= 1'b1;
                                stopped_o  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Bench for clk_freq_monitor: mon_clk_i edges are driven at a fixed offset after clk_i,
// and a reference model turns edge times into expected averaged periods and flags.
module tb_clk_freq_monitor;

    logic        clk_i        = 1'b0;
    logic        rst_ni       = 1'b0;
    logic        en_i         = 1'b0;
    logic        clr_i        = 1'b0;
    logic        mon_clk_i    = 1'b0;
    logic [15:0] min_period_i = '0;
    logic [15:0] max_period_i = '0;
    logic [15:0] period_o;
    logic        period_valid_o;
    logic        too_fast_o;
    logic        too_slow_o;
    logic        stopped_o;

    clk_freq_monitor #(
        .SYNC_STAGES(2),
        .CNT_W      (16),
        .AVG_LOG2   (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .clr_i         (clr_i),
        .mon_clk_i     (mon_clk_i),
        .min_period_i  (min_period_i),
        .max_period_i  (max_period_i),
        .period_o      (period_o),
        .period_valid_o(period_valid_o),
        .too_fast_o    (too_fast_o),
        .too_slow_o    (too_slow_o),
        .stopped_o     (stopped_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference model: periods are differences of mon rise times in clk_i cycles.
    bit     m_en    = 0;
    bit     m_armed = 0;
    bit     m_tf    = 0;
    bit     m_ts    = 0;
    int     m_last  = 0;
    int     m_n     = 0;
    longint m_acc   = 0;
    int     exp_q[$];

    function automatic void model_rise();
        int d;
        int p;
        if (!m_en) return;
        if (!m_armed) begin
            m_armed = 1;
            m_last  = cyc;
            return;
        end
        d      = cyc - m_last;
        m_last = cyc;
        p      = (d > 65535) ? 65535 : d;
        if (min_period_i != 0 && p < int'(min_period_i)) m_tf = 1;
        if (max_period_i != 0 && d > int'(max_period_i)) m_ts = 1;
        m_acc += p;
        m_n++;
        if (m_n == 4) begin
            exp_q.push_back(int'(m_acc / 4));
            m_acc = 0;
            m_n   = 0;
        end
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic mon_period(input int hi, input int lo);
        mon_clk_i = 1'b1;
        model_rise();
        step(hi);
        mon_clk_i = 1'b0;
        step(lo);
    endtask

    task automatic set_en(input bit v);
        en_i = v;
        m_en = v;
        if (!v) begin
            m_armed = 0;
            m_acc   = 0;
            m_n     = 0;
        end
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        m_tf  = 0;
        m_ts  = 0;
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".too_fast"}, too_fast_o, m_tf);
        chk({tag, ".too_slow"}, too_slow_o, m_ts);
    endtask

    task automatic restart(input int minp, input int maxp);
        set_en(0);
        step(2);
        min_period_i = 16'(minp);
        max_period_i = 16'(maxp);
        do_clr();
        set_en(1);
        step(3);
    endtask

    // Scoreboard: every period_valid_o pulse must deliver the next modelled result.
    always @(negedge clk_i) begin
        if (rst_ni && period_valid_o === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL valid_unexpected: period_o=%0d with no result due", period_o);
            end else begin
                chk("sb.period_o", period_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int hi;
        int lo;
        int nper;
        int minp;
        int maxp;
        int exp_per;
        bit exp_tf;
        bit exp_ts;
    } vec_t;

    vec_t vt[6];

    initial begin
        int v0;
        vt[0] = '{4, 4, 8, 0,  0, 8, 0, 0};
        vt[1] = '{3, 3, 4, 0,  0, 6, 0, 0};
        vt[2] = '{5, 4, 4, 9,  9, 9, 0, 0};
        vt[3] = '{5, 4, 4, 10, 0, 9, 1, 0};
        vt[4] = '{5, 4, 4, 0,  8, 9, 0, 1};
        vt[5] = '{2, 2, 4, 0,  0, 4, 0, 0};

        // Reset values
        step(3);
        chk("rst.period_o", period_o, 0);
        chk("rst.valid", period_valid_o, 0);
        chk("rst.too_fast", too_fast_o, 0);
        chk("rst.too_slow", too_slow_o, 0);
        chk("rst.stopped", stopped_o, 0);
        rst_ni = 1'b1;
        step(2);

        // Steady patterns from the table
        for (int i = 0; i < 6; i++) begin
            restart(vt[i].minp, vt[i].maxp);
            repeat (vt[i].nper + 1) mon_period(vt[i].hi, vt[i].lo);
            chk($sformatf("row%0d.period_o", i), period_o, vt[i].exp_per);
            chk($sformatf("row%0d.too_fast", i), too_fast_o, vt[i].exp_tf);
            chk($sformatf("row%0d.too_slow", i), too_slow_o, vt[i].exp_ts);
            set_en(0);
            step(2);
            chk($sformatf("row%0d.stopped_idle", i), stopped_o, 0);
        end

        // First result only after the arming edge plus four periods
        restart(0, 0);
        v0 = n_valid;
        repeat (4) mon_period(4, 4);
        chk("t1.no_early_valid", n_valid - v0, 0);
        mon_period(4, 4);
        chk("t1.first_valid", n_valid - v0, 1);
        chk("t1.period_o", period_o, 8);
        repeat (4) mon_period(4, 4);
        chk("t1.second_valid", n_valid - v0, 2);

        // Alternating 7/9 periods, then a live min bound
        restart(0, 0);
        mon_period(3, 4);
        mon_period(4, 5);
        mon_period(3, 4);
        mon_period(4, 5);
        mon_period(3, 4);
        chk("t2.period_o", period_o, 8);
        chk("t2.tf_before", too_fast_o, 0);
        min_period_i = 16'd8;
        mon_period(4, 5);
        chk("t2.tf_after_7", too_fast_o, 1);
        chk_flags("t2");

        // clr in the same cycle as a new too_fast set: set wins
        do_clr();
        chk("t4.cleared", too_fast_o, 0);
        min_period_i = 16'd12;
        mon_clk_i = 1'b1;
        model_rise();
        step(3);
        clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        chk("t4.set_wins", too_fast_o, 1);
        mon_clk_i = 1'b0;
        step(4);
        do_clr();
        chk("t4.clr_after", too_fast_o, 0);

        // Stopped clock with max bound 20
        restart(0, 20);
        repeat (5) mon_period(4, 4);
        mon_clk_i = 1'b1;
        model_rise();
        step(23);
        chk("t3.stopped_early", stopped_o, 0);
        chk("t3.slow_early", too_slow_o, 0);
        step(1);
        m_ts = 1;
        chk("t3.stopped_at_20", stopped_o, 1);
        chk("t3.slow_at_20", too_slow_o, 1);
        step(10);
        chk("t3.stopped_hold", stopped_o, 1);
        mon_clk_i = 1'b0;
        step(4);
        mon_period(4, 4);
        chk("t3.stopped_clears", stopped_o, 0);
        chk("t3.slow_sticky", too_slow_o, 1);
        chk_flags("t3");
        do_clr();
        chk("t3.slow_clr", too_slow_o, 0);

        // Disable mid-average, then re-enable
        restart(0, 0);
        v0 = n_valid;
        repeat (3) mon_period(4, 4);
        set_en(0);
        step(5);
        set_en(1);
        step(3);
        chk("t5.no_valid", n_valid - v0, 0);
        repeat (5) mon_period(5, 5);
        chk("t5.valid_count", n_valid - v0, 1);
        chk("t5.period_o", period_o, 10);

        // Saturating counter on a long low phase
        restart(0, 0);
        mon_period(4, 4);
        mon_period(4, 4);
        mon_period(4, 65540);
        mon_period(4, 4);
        mon_period(4, 4);
        chk("t6.period_o", period_o, 16389);
        chk("t6.too_fast", too_fast_o, 0);
        chk("t6.too_slow", too_slow_o, 0);
        chk("t6.stopped", stopped_o, 0);

        // Randomized periods and bounds against the model
        for (int s = 0; s < 12; s++) begin
            int n;
            int minp;
            int maxp;
            minp = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 16));
            maxp = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(6, 24));
            restart(minp, maxp);
            n = int'($urandom_range(5, 12));
            repeat (n) mon_period(int'($urandom_range(2, 8)), int'($urandom_range(2, 8)));
            mon_clk_i = 1'b1;
            model_rise();
            step(5);
            chk_flags($sformatf("rnd%0d", s));
            mon_clk_i = 1'b0;
            step(3);
            set_en(0);
        end

        // Asynchronous reset mid-measurement
        restart(0, 0);
        repeat (3) mon_period(4, 4);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst.period_o", period_o, 0);
        chk("arst.too_fast", too_fast_o, 0);
        chk("arst.too_slow", too_slow_o, 0);
        exp_q.delete();
        m_armed = 0;
        m_acc   = 0;
        m_n     = 0;
        m_tf    = 0;
        m_ts    = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(3);
        repeat (5) mon_period(4, 4);
        chk("arst.recover", period_o, 8);

        step(10);
        chk("pending_results", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
